// File: rtl/cc_fill_read_pipe.sv
// Code-cache front/back pipe: registered fetch request, per-offset slice select with a
// stall-holding output stage plus one-entry skid, and beat-wise line assembly for fills.
module cc_fill_read_pipe #(
  parameter int SLICE_W = 260,
  parameter int SLICES  = 4,
  parameter int BEATS   = 2,
  parameter int X_W     = 15,
  parameter int IP_W    = 44,
  parameter int OFS_LO  = 5,
  localparam int LINE_W = SLICE_W * SLICES,
  localparam int BEAT_W = LINE_W / BEATS
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    read_clkEn,
  input  logic [IP_W-1:0]         read_IP,
  input  logic                    fstall,
  input  logic                    except,
  output logic                    ram_read_en,
  output logic [IP_W-1:0]         ram_read_IP,
  input  logic [LINE_W-1:0]       ram_read_data,
  input  logic [SLICES*X_W-1:0]   ram_read_dataX,
  input  logic                    ram_read_hit,
  input  logic [7:0]              ram_tagErr,
  output logic                    read_valid,
  output logic                    read_hit,
  output logic [7:0]              read_tagErr,
  output logic [SLICE_W-1:0]      read_data,
  output logic [X_W-1:0]          read_dataX,
  input  logic                    write_wen,
  input  logic [BEAT_W-1:0]       write_data,
  input  logic [IP_W-1:0]         write_IP,
  input  logic                    invalidate,
  output logic                    ram_write_wen,
  output logic                    ram_invalidate,
  output logic [IP_W-1:0]         ram_write_IP,
  output logic [LINE_W-1:0]       ram_write_data,
  output logic                    fill_busy
);
  localparam int OFS_W = $clog2(SLICES);
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef struct packed {
    logic               hit;
    logic [7:0]         tag_err;
    logic [SLICE_W-1:0] data;
    logic [X_W-1:0]     data_x;
  } rd_res_t;

  logic             a_valid;
  logic [IP_W-1:0]  a_ip;
  logic [OFS_W-1:0] a_ofs;
  logic             b_valid;
  logic [OFS_W-1:0] b_ofs;
  rd_res_t          b_res;
  rd_res_t          sk_res;
  rd_res_t          out_res;
  logic             sk_valid;
  logic             out_valid;
  logic [CNT_W-1:0] beat_cnt;

  // request and RAM-return stages keep flowing under stall; the skid absorbs the overhang
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_ip    <= '0;
      a_ofs   <= '0;
      b_valid <= 1'b0;
      b_ofs   <= '0;
    end else begin
      a_valid <= read_clkEn & ~except;
      a_ip    <= read_IP;
      a_ofs   <= read_IP[OFS_LO +: OFS_W];
      b_valid <= a_valid & ~except;
      b_ofs   <= a_ofs;
    end
  end

  always_comb begin
    b_res.hit     = ram_read_hit;
    b_res.tag_err = ram_tagErr;
    b_res.data    = '0;
    b_res.data_x  = '0;
    if (ram_read_hit) begin
      b_res.data   = ram_read_data[int'(b_ofs)*SLICE_W +: SLICE_W];
      b_res.data_x = ram_read_dataX[int'(b_ofs)*X_W +: X_W];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_res   <= '0;
      sk_valid  <= 1'b0;
      sk_res    <= '0;
    end else if (except) begin
      out_valid   <= 1'b0;
      out_res.hit <= 1'b0;
      sk_valid    <= 1'b0;
    end else if (!fstall) begin
      if (sk_valid) begin
        // older skid entry goes out first; this cycle's return waits in the skid
        out_valid <= 1'b1;
        out_res   <= sk_res;
        sk_valid  <= b_valid;
        if (b_valid) sk_res <= b_res;
      end else begin
        out_valid <= b_valid;
        if (b_valid) out_res <= b_res;
        else out_res.hit <= 1'b0;
      end
    end else if (b_valid) begin
      if (!out_valid) begin
        out_valid <= 1'b1;
        out_res   <= b_res;
      end else if (!sk_valid) begin
        sk_valid <= 1'b1;
        sk_res   <= b_res;
      end
    end
  end

  assign ram_read_en = a_valid;
  assign ram_read_IP = a_ip;
  assign read_valid  = out_valid;
  assign read_hit    = out_res.hit;
  assign read_tagErr = out_res.tag_err;
  assign read_data   = out_res.data;
  assign read_dataX  = out_res.data_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      beat_cnt       <= '0;
      ram_write_wen  <= 1'b0;
      ram_invalidate <= 1'b0;
      ram_write_IP   <= '0;
      ram_write_data <= '0;
    end else begin
      ram_write_wen  <= 1'b0;
      ram_invalidate <= 1'b0;
      if (invalidate) begin
        ram_invalidate <= 1'b1;
        ram_write_IP   <= write_IP;
        beat_cnt       <= '0;
      end else if (write_wen) begin
        ram_write_data[int'(beat_cnt)*BEAT_W +: BEAT_W] <= write_data;
        if (beat_cnt == '0) ram_write_IP <= write_IP;
        if (int'(beat_cnt) == BEATS - 1) begin
          beat_cnt      <= '0;
          ram_write_wen <= 1'b1;
        end else begin
          beat_cnt <= beat_cnt + 1'b1;
        end
      end
    end
  end

  assign fill_busy = (beat_cnt != '0);

endmodule
